xs_sdr_rom_arbiter: RTL and testbench
=====================================

Name: xs_sdr_rom_arbiter

Overview:
- Shares the single SDRAM ROM read port (sdr_addr/sdr_req/sdr_rdy/sdr_data) between the graphics ROM fetchers: BACK1, BACK2, OBJ, plus one spare.
- Each fetcher keeps its own falling-HCLKn request generator and emits a one-cycle req pulse with a 25-bit address. The arbiter captures the pulse and serialises requests round-robin to the SDRAM controller.
- The returned 16-bit word is routed back to the originating client with a one-cycle rdy pulse.
- Sits in the clk_ram domain, between the video layer modules and the SDRAM controller.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 25, SDRAM byte address width.
- DW, 16, SDRAM data width.
- TIMEOUT, 255, maximum clk_ram cycles spent in WAIT before aborting (1..1023).

Ports:
- clk_ram  in  1  SDRAM-side clock; all logic on its rising edge.
- RESET  in  1  Synchronous, active-high reset.
- cli_req  in  NREQ  Per-client request pulse (one clk_ram cycle).
- cli_addr  in  NREQ*AW  Per-client address; slice i belongs to client i; sampled only when cli_req[i]=1.
- cli_rdy  out  NREQ  One-hot, one-cycle pulse: cli_data is valid for that client.
- cli_data  out  DW  Returned word, shared by all clients; valid only with cli_rdy.
- sdr_addr  out  AW  Address presented to the SDRAM controller.
- sdr_req  out  1  One-cycle request pulse to the SDRAM controller.
- sdr_rdy  in  1  One-cycle read-complete pulse from the SDRAM controller.
- sdr_data  in  DW  Read data, valid with sdr_rdy.
- busy  out  1  1 while in WAIT.
- tmo_err  out  1  Sticky flag, set on timeout; cleared only by RESET.

Behaviour:
- Reset values: cli_rdy=0, cli_data=0, sdr_addr=0, sdr_req=0, busy=0, tmo_err=0, all pend bits=0, rr_last=NREQ-1, state=IDLE, timer=0.
- Capture: for each i, if cli_req[i], then pend[i]<=1 and paddr[i]<=cli_addr[i]. A repeat request while pending overwrites paddr (latest wins). Capture has priority over grant-clear in the same cycle.
- FSM IDLE: if any pend bit is set, g = first pending index scanning rr_last+1 .. rr_last+NREQ modulo NREQ. Then: sdr_addr<=paddr[g]; sdr_req<=1 for one cycle; pend[g]<=0, unless cli_req[g] is high in the same cycle, in which case it stays 1 with the new address; gnt<=g; rr_last<=g; timer<=0; go to WAIT.
- FSM WAIT: busy=1; timer increments.
  - On sdr_rdy: cli_data<=sdr_data; cli_rdy[gnt]<=1 for one cycle; go to IDLE.
  - Else if timer==TIMEOUT-1: tmo_err<=1; no cli_rdy; go to IDLE.
- Pending bits of the in-flight client may be set again during WAIT; that is a new request.
- Latency:
  - Request into idle arbiter: cli_req at edge t gives sdr_req high after edge t+1.
  - Return: sdr_rdy at edge u gives cli_rdy after edge u+1.
  - Back-to-back: the next sdr_req is issued one cycle after cli_rdy (WAIT→IDLE→issue).
- sdr_rdy in IDLE is ignored: no cli_rdy, and cli_data is unchanged. This covers a stale return after timeout or reset.
- Simultaneous req from all clients: served in round-robin order starting after rr_last. No client waits more than NREQ-1 grants.
- RESET mid-WAIT: state goes to IDLE and all pending requests are dropped. Any later stray sdr_rdy is ignored.
- No address arithmetic: addresses pass through unmodified. Region base OR-ing stays in each client.

Decomposition:
- Shared package (xain_pkg):
  - SDR_ARB_NREQ=4.
  - Client index constants CLI_BACK1=0, CLI_BACK2=1, CLI_OBJ=2, CLI_SPARE=3.
  - Enum sdr_arb_state_t {ARB_IDLE, ARB_WAIT}.
- One sub-module: xs_rr_pick. It is combinational: inputs pend[NREQ] and rr_last; outputs found and g. It is unit-testable on its own.

Test Plan:
- Single request: cli_req[0] with addr 25'h0123450 at t, sdr_rdy with 16'hBEEF 6 cycles after sdr_req → sdr_req after t+1 with sdr_addr=0123450; cli_rdy=4'b0001 and cli_data=BEEF one cycle after sdr_rdy.
- Fairness: all 4 clients pulse simultaneously, rr_last=3, controller latency 4 → grant order 0,1,2,3. Each sees exactly one cli_rdy; sdr_req pulses are spaced 6 cycles apart.
- Overwrite: client 1 requests addr A, then addr B while client 0 is in flight → only B is issued for client 1; a single sdr_req is issued for client 1.
- Same-cycle re-request: cli_req[2] is asserted in the same cycle client 2 is granted → the second request stays pending and is issued after the current transaction completes.
- Timeout: TIMEOUT=8, sdr_rdy withheld → after 8 WAIT cycles the arbiter returns to IDLE with tmo_err=1 and no cli_rdy. A late sdr_rdy is then ignored and cli_data is unchanged.
- Reset mid-WAIT: RESET for 1 cycle while client 3 is in flight with client 0 pending → all outputs at reset values. The subsequent sdr_rdy yields no cli_rdy, and no sdr_req is issued until a new cli_req.

Source files
------------

// File: rtl/xain_pkg.sv
// Shared definitions for the xain video/SDRAM glue: client indices and ROM arbiter state encoding.
package xain_pkg;

    localparam int SDR_ARB_NREQ = 4;

    localparam int CLI_BACK1 = 0;
    localparam int CLI_BACK2 = 1;
    localparam int CLI_OBJ   = 2;
    localparam int CLI_SPARE = 3;

    typedef enum logic {
        ARB_IDLE,
        ARB_WAIT
    } sdr_arb_state_t;

endpackage

// File: rtl/xs_rr_pick.sv
// Round-robin selector: first set pend bit scanning upward from rr_last+1, wrapping modulo NREQ.
module xs_rr_pick #(
    parameter int NREQ = 4,
    parameter int LW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] pend,
    input  logic [LW-1:0]   rr_last,
    output logic            found,
    output logic [LW-1:0]   g
);

    int idx;

    // Scan from the far end so the candidate nearest rr_last+1 is written last and wins.
    always_comb begin
        found = 1'b0;
        g     = '0;
        idx   = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(rr_last) + k) % NREQ;
            if (pend[idx[LW-1:0]]) begin
                found = 1'b1;
                g     = LW'(idx);
            end
        end
    end

endmodule

// File: rtl/xs_sdr_rom_arbiter.sv
// Serialises one-cycle ROM fetch pulses from the video layer clients onto the single SDRAM read port,
// round-robin, and routes each returned word back to its requester.
module xs_sdr_rom_arbiter
    import xain_pkg::*;
#(
    parameter int NREQ    = SDR_ARB_NREQ,
    parameter int AW      = 25,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic               clk_ram,
    input  logic               RESET,
    input  logic [NREQ-1:0]    cli_req,
    input  logic [NREQ*AW-1:0] cli_addr,
    output logic [NREQ-1:0]    cli_rdy,
    output logic [DW-1:0]      cli_data,
    output logic [AW-1:0]      sdr_addr,
    output logic               sdr_req,
    input  logic               sdr_rdy,
    input  logic [DW-1:0]      sdr_data,
    output logic               busy,
    output logic               tmo_err
);

    localparam int LW = $clog2(NREQ);
    localparam int TW = 10;

    sdr_arb_state_t  state_q, state_d;
    logic [NREQ-1:0] pend_q, pend_d;
    logic [AW-1:0]   paddr_q [NREQ];
    logic [AW-1:0]   paddr_d [NREQ];
    logic [LW-1:0]   gnt_q, gnt_d;
    logic [LW-1:0]   rr_last_q, rr_last_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [NREQ-1:0] cli_rdy_q, cli_rdy_d;
    logic [DW-1:0]   cli_data_q, cli_data_d;
    logic [AW-1:0]   sdr_addr_q, sdr_addr_d;
    logic            sdr_req_q, sdr_req_d;
    logic            tmo_err_q, tmo_err_d;

    logic            pick_found;
    logic [LW-1:0]   pick_g;

    xs_rr_pick #(.NREQ(NREQ), .LW(LW)) u_rr_pick (
        .pend    (pend_q),
        .rr_last (rr_last_q),
        .found   (pick_found),
        .g       (pick_g)
    );

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        paddr_d    = paddr_q;
        gnt_d      = gnt_q;
        rr_last_d  = rr_last_q;
        timer_d    = timer_q;
        cli_rdy_d  = '0;
        cli_data_d = cli_data_q;
        sdr_addr_d = sdr_addr_q;
        sdr_req_d  = 1'b0;
        tmo_err_d  = tmo_err_q;

        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    sdr_addr_d     = paddr_q[pick_g];
                    sdr_req_d      = 1'b1;
                    pend_d[pick_g] = 1'b0;
                    gnt_d          = pick_g;
                    rr_last_d      = pick_g;
                    timer_d        = '0;
                    state_d        = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                timer_d = timer_q + TW'(1);
                if (sdr_rdy) begin
                    cli_data_d       = sdr_data;
                    cli_rdy_d[gnt_q] = 1'b1;
                    state_d          = ARB_IDLE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    tmo_err_d = 1'b1;
                    state_d   = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        // A fresh pulse beats the grant-clear above, so a same-cycle re-request stays queued.
        for (int i = 0; i < NREQ; i++) begin
            if (cli_req[i]) begin
                pend_d[i]  = 1'b1;
                paddr_d[i] = cli_addr[i*AW +: AW];
            end
        end
    end

    always_ff @(posedge clk_ram) begin
        if (RESET) begin
            state_q    <= ARB_IDLE;
            pend_q     <= '0;
            gnt_q      <= '0;
            rr_last_q  <= LW'(NREQ - 1);
            timer_q    <= '0;
            cli_rdy_q  <= '0;
            cli_data_q <= '0;
            sdr_addr_q <= '0;
            sdr_req_q  <= 1'b0;
            tmo_err_q  <= 1'b0;
            for (int i = 0; i < NREQ; i++) paddr_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            gnt_q      <= gnt_d;
            rr_last_q  <= rr_last_d;
            timer_q    <= timer_d;
            cli_rdy_q  <= cli_rdy_d;
            cli_data_q <= cli_data_d;
            sdr_addr_q <= sdr_addr_d;
            sdr_req_q  <= sdr_req_d;
            tmo_err_q  <= tmo_err_d;
            for (int i = 0; i < NREQ; i++) paddr_q[i] <= paddr_d[i];
        end
    end

    assign cli_rdy  = cli_rdy_q;
    assign cli_data = cli_data_q;
    assign sdr_addr = sdr_addr_q;
    assign sdr_req  = sdr_req_q;
    assign tmo_err  = tmo_err_q;
    assign busy     = (state_q == ARB_WAIT);

endmodule

// File: tb/tb_xs_sdr_rom_arbiter.sv
// Bench for xs_sdr_rom_arbiter: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a transaction-level reference model.
module tb_xs_sdr_rom_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 25;
    localparam int DW   = 16;
    localparam int TMO  = 8;

    logic               clk_ram = 1'b0;
    logic               RESET   = 1'b1;
    logic [NREQ-1:0]    cli_req = '0;
    logic [NREQ*AW-1:0] cli_addr = '0;
    logic [NREQ-1:0]    cli_rdy;
    logic [DW-1:0]      cli_data;
    logic [AW-1:0]      sdr_addr;
    logic               sdr_req;
    logic               sdr_rdy = 1'b0;
    logic [DW-1:0]      sdr_data = '0;
    logic               busy;
    logic               tmo_err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk_ram = ~clk_ram;

    xs_sdr_rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk_ram  (clk_ram),
        .RESET    (RESET),
        .cli_req  (cli_req),
        .cli_addr (cli_addr),
        .cli_rdy  (cli_rdy),
        .cli_data (cli_data),
        .sdr_addr (sdr_addr),
        .sdr_req  (sdr_req),
        .sdr_rdy  (sdr_rdy),
        .sdr_data (sdr_data),
        .busy     (busy),
        .tmo_err  (tmo_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // SDRAM controller stand-in: answers each sdr_req after a latency, plus on-demand stray pulses.
    logic          resp_en   = 1'b0;
    logic          resp_rand = 1'b0;
    int            resp_lat  = 4;
    logic [DW-1:0] resp_word = '0;
    int            stray_req = 0;
    int            stray_done = 0;
    int            resp_cnt  = 0;

    always @(negedge clk_ram) begin
        sdr_rdy  = 1'b0;
        sdr_data = DW'($urandom);
        if (stray_req != stray_done) begin
            sdr_rdy    = 1'b1;
            stray_done = stray_req;
        end else if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                sdr_rdy  = 1'b1;
                sdr_data = resp_rand ? DW'($urandom) : resp_word;
            end
        end
        if (resp_en && sdr_req) resp_cnt = resp_rand ? int'($urandom_range(1, 10)) : resp_lat;
    end

    // Reference model: pending requests as a per-client table, one outstanding transaction at a time.
    logic            m_valid = 1'b0;
    bit              m_wait;
    int              m_gnt, m_rr, m_g;
    bit              m_pend [NREQ];
    logic [AW-1:0]   m_paddr [NREQ];
    longint          cyc = 0;
    longint          m_issue;
    logic [NREQ-1:0] m_cli_rdy;
    logic [DW-1:0]   m_cli_data;
    logic [AW-1:0]   m_sdr_addr;
    logic            m_sdr_req, m_tmo;

    always @(posedge clk_ram) begin
        cyc++;
        if (RESET) begin
            m_valid    = 1'b1;
            m_wait     = 1'b0;
            m_gnt      = 0;
            m_rr       = NREQ - 1;
            m_cli_rdy  = '0;
            m_cli_data = '0;
            m_sdr_addr = '0;
            m_sdr_req  = 1'b0;
            m_tmo      = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                m_pend[i]  = 1'b0;
                m_paddr[i] = '0;
            end
        end else begin
            m_cli_rdy = '0;
            m_sdr_req = 1'b0;
            if (!m_wait) begin
                m_g = -1;
                for (int k = 1; k <= NREQ; k++)
                    if (m_g < 0 && m_pend[(m_rr + k) % NREQ]) m_g = (m_rr + k) % NREQ;
                if (m_g >= 0) begin
                    m_sdr_addr     = m_paddr[m_g];
                    m_sdr_req      = 1'b1;
                    m_pend[m_g]    = 1'b0;
                    m_gnt          = m_g;
                    m_rr           = m_g;
                    m_issue        = cyc;
                    m_wait         = 1'b1;
                end
            end else if (sdr_rdy) begin
                m_cli_data        = sdr_data;
                m_cli_rdy[m_gnt]  = 1'b1;
                m_wait            = 1'b0;
            end else if (cyc - m_issue == longint'(TMO)) begin
                m_tmo  = 1'b1;
                m_wait = 1'b0;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (cli_req[i]) begin
                    m_pend[i]  = 1'b1;
                    m_paddr[i] = cli_addr[i*AW +: AW];
                end
            end
        end
    end

    always @(negedge clk_ram) begin
        if (m_valid) begin
            chk("cli_rdy",  cli_rdy,  m_cli_rdy);
            chk("cli_data", cli_data, m_cli_data);
            chk("sdr_req",  sdr_req,  m_sdr_req);
            if (m_sdr_req) chk("sdr_addr", sdr_addr, m_sdr_addr);
            chk("busy",     busy,     m_wait);
            chk("tmo_err",  tmo_err,  m_tmo);
        end
    end

    // Observation helpers for the directed scenarios.
    logic [AW-1:0] q_addr [$];
    int            q_t [$];
    int            rdy_per [NREQ];
    int            rdy_tot, busy_cnt;

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        cli_addr[i*AW +: AW] = a;
    endtask

    task automatic do_reset();
        @(negedge clk_ram);
        RESET = 1'b1;
        @(negedge clk_ram);
        RESET = 1'b0;
    endtask

    task automatic mon(input int n);
        q_addr.delete();
        q_t.delete();
        rdy_tot  = 0;
        busy_cnt = 0;
        for (int i = 0; i < NREQ; i++) rdy_per[i] = 0;
        for (int c = 0; c < n; c++) begin
            if (sdr_req) begin
                q_addr.push_back(sdr_addr);
                q_t.push_back(c);
            end
            for (int i = 0; i < NREQ; i++) if (cli_rdy[i]) rdy_per[i]++;
            if (cli_rdy != '0) rdy_tot++;
            if (busy) busy_cnt++;
            @(negedge clk_ram);
        end
    endtask

    task automatic wait_sdr_req(input int lim, output int n);
        n = 0;
        do begin
            @(negedge clk_ram);
            n++;
        end while (!sdr_req && n < lim);
        chk("sdr_req_seen", sdr_req, 1);
    endtask

    task automatic wait_cli_rdy(input int lim, output int n);
        n = 0;
        do begin
            @(negedge clk_ram);
            n++;
        end while (cli_rdy == '0 && n < lim);
        chk("cli_rdy_seen", (cli_rdy != '0), 1);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk_ram);
        RESET = 1'b0;
        chk("rst_sdr_req", sdr_req, 0);
        chk("rst_cli_rdy", cli_rdy, 0);
        chk("rst_busy",    busy,    0);
        chk("rst_tmo",     tmo_err, 0);

        // Single request with a 6-cycle controller.
        resp_en = 1'b1; resp_rand = 1'b0; resp_lat = 6; resp_word = 16'hBEEF;
        set_addr(0, 25'h0123450);
        cli_req = 4'b0001;
        @(negedge clk_ram);
        cli_req = '0;
        wait_sdr_req(20, n);
        chk("single_req_lat", n + 1, 2);
        chk("single_addr", sdr_addr, 25'h0123450);
        wait_cli_rdy(20, n);
        chk("single_rdy_lat", n, 7);
        chk("single_rdy", cli_rdy, 4'b0001);
        chk("single_data", cli_data, 16'hBEEF);

        // All four clients at once from reset: order 0..3, one slot every 6 cycles.
        do_reset();
        resp_lat = 4;
        for (int i = 0; i < NREQ; i++) set_addr(i, AW'(32'h1000 + i));
        cli_req = 4'b1111;
        @(negedge clk_ram);
        cli_req = '0;
        mon(40);
        chk("fair_count", q_addr.size(), 4);
        for (int k = 0; k < 4 && k < q_addr.size(); k++) begin
            chk("fair_order", q_addr[k], 32'h1000 + k);
            if (k > 0) chk("fair_spacing", q_t[k] - q_t[k-1], 6);
            chk("fair_rdy_once", rdy_per[k], 1);
        end

        // Client 1 re-requests while client 0 is in flight: only the latest address goes out.
        do_reset();
        set_addr(0, 25'h0002000);
        cli_req = 4'b0001;
        @(negedge clk_ram);
        cli_req = '0;
        wait_sdr_req(20, n);
        set_addr(1, 25'h0002A00);
        cli_req = 4'b0010;
        @(negedge clk_ram);
        cli_req = '0;
        @(negedge clk_ram);
        set_addr(1, 25'h0002B00);
        cli_req = 4'b0010;
        @(negedge clk_ram);
        cli_req = '0;
        mon(30);
        chk("ovw_count", q_addr.size(), 1);
        if (q_addr.size() > 0) chk("ovw_addr", q_addr[0], 25'h0002B00);
        chk("ovw_rdy1", rdy_per[1], 1);

        // Re-request by client 2 in the very cycle it is granted.
        do_reset();
        set_addr(2, 25'h0000C00);
        cli_req = 4'b0100;
        @(negedge clk_ram);
        set_addr(2, 25'h0000D00);
        @(negedge clk_ram);
        cli_req = '0;
        mon(30);
        chk("same_count", q_addr.size(), 2);
        if (q_addr.size() > 1) begin
            chk("same_first", q_addr[0], 25'h0000C00);
            chk("same_second", q_addr[1], 25'h0000D00);
        end
        chk("same_rdy2", rdy_per[2], 2);

        // Withheld response: eight WAIT cycles, sticky error, late return ignored.
        do_reset();
        resp_en = 1'b0;
        set_addr(0, 25'h0003000);
        cli_req = 4'b0001;
        @(negedge clk_ram);
        cli_req = '0;
        mon(20);
        chk("tmo_busy_cycles", busy_cnt, 8);
        chk("tmo_no_rdy", rdy_tot, 0);
        chk("tmo_flag", tmo_err, 1);
        stray_req++;
        mon(5);
        chk("tmo_late_rdy", rdy_tot, 0);
        chk("tmo_data_kept", cli_data, 0);
        chk("tmo_sticky", tmo_err, 1);

        // Reset while client 3 is in flight and client 0 is queued.
        do_reset();
        set_addr(3, 25'h0003333);
        cli_req = 4'b1000;
        @(negedge clk_ram);
        cli_req = '0;
        wait_sdr_req(20, n);
        chk("rstw_addr", sdr_addr, 25'h0003333);
        set_addr(0, 25'h0000111);
        cli_req = 4'b0001;
        @(negedge clk_ram);
        cli_req = '0;
        RESET = 1'b1;
        @(negedge clk_ram);
        RESET = 1'b0;
        chk("rstw_busy", busy, 0);
        chk("rstw_sdr_addr", sdr_addr, 0);
        chk("rstw_tmo", tmo_err, 0);
        stray_req++;
        mon(12);
        chk("rstw_no_rdy", rdy_tot, 0);
        chk("rstw_no_req", q_addr.size(), 0);

        // Randomized traffic, mixed latencies (some beyond the timeout), stray returns, rare resets.
        do_reset();
        resp_en = 1'b1;
        resp_rand = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_ram);
            for (int i = 0; i < NREQ; i++) begin
                cli_req[i] = ($urandom_range(0, 3) == 0);
                set_addr(i, AW'($urandom));
            end
            if ($urandom_range(0, 49) == 0) stray_req++;
            RESET = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk_ram);
        cli_req = '0;
        RESET = 1'b0;
        repeat (20) @(negedge clk_ram);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
